carrier_cfg_ctrl: RTL
=====================

# carrier_cfg_ctrl

Configuration controller for the carrier generator in the QAM modulator. Accepts frequency change requests over a valid/ready handshake and range-checks them. Applies each accepted frequency only on a symbol boundary, so the I/Q carriers never change frequency mid-symbol. On every real change it issues a one-cycle carrier phase-reset pulse, which restarts both sine generators aligned.

## Interface
Parameters:
- SYM_LEN, 64, clock cycles per symbol; ≥ 2.
- FREQ_MAX, 57260, highest legal carrier frequency in Hz.
- DEFAULT_FREQ, 10000, frequency driven out of reset.

Ports:
- clk  in  1  system clock (230,401.25 Hz carrier-generator domain).
- rst_n  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  request valid.
- cfg_freq  in  16  requested frequency, Hz.
- cfg_ready  out  1  controller can accept a request.
- cfg_err  out  1  sticky: an out-of-range request was rejected.
- busy  out  1  request pending, not yet applied.
- freq  out  16  frequency to the carrier generator.
- freq_upd  out  1  one-cycle pulse: freq just changed.
- carrier_rst_n  out  1  active-low phase reset for the carrier generator.
- sym_strobe  out  1  one-cycle pulse on the last cycle of each symbol.

## Operation
- Symbol timer:
  - sym_cnt counts 0..SYM_LEN-1 and wraps to 0.
  - It is free-running from reset release.
  - sym_strobe = (sym_cnt == SYM_LEN-1).
- States:
  - IDLE: cfg_ready=1, busy=0.
  - PEND: cfg_ready=0, busy=1.
- IDLE, on a handshake (cfg_valid & cfg_ready):
  - If cfg_freq == 0 or cfg_freq > FREQ_MAX: reject, set cfg_err, stay in IDLE.
  - Otherwise: latch cfg_freq into pend_freq, clear cfg_err, go to PEND.
- PEND, on a cycle with sym_strobe=1:
  - Go to IDLE.
  - If pend_freq ≠ freq: next cycle freq ← pend_freq, freq_upd=1, carrier_rst_n=0, each for exactly one cycle.
  - If pend_freq == freq: no pulses, freq unchanged.
- Strobe at acceptance: a request accepted on a cycle where sym_strobe=1 does not use that strobe. It waits for the next one (PEND is entered after that edge).
- cfg_freq is ignored while cfg_ready=0; requests are never queued.
- Width rules: 16-bit unsigned compare against FREQ_MAX; no arithmetic on freq.

## Timing
- Reset values: state=IDLE, sym_cnt=0, sym_strobe=0, cfg_ready=1, busy=0, cfg_err=0, freq=DEFAULT_FREQ, freq_upd=0, carrier_rst_n=0.
- carrier_rst_n rises to 1 on the first clk edge after rst_n deasserts.
- Reset mid-PEND discards pend_freq; freq returns to DEFAULT_FREQ.
- All outputs are registered; no combinational path from cfg_* to any output.
- Latency: accept at edge t → freq changes at the edge following the first sym_strobe cycle after t. Minimum 1 cycle, maximum SYM_LEN cycles after PEND entry.
- freq_upd, carrier_rst_n low and the new freq all occur in the same cycle. That cycle is sym_cnt == 0 of the new symbol.
- Back-to-back: cfg_ready returns to 1 in the cycle the new freq appears, so the next request can be accepted immediately.

## Structure
- Shared package carrier_pkg holds:
  - FREQ_W = 16
  - FREQ_MAX_HZ = 57260
  - the state enum {IDLE, PEND}
  - the carrier-generator clock rate constant
- Sub-module sym_timer (SYM_LEN parameter; outputs sym_cnt and sym_strobe). It is reused later by the symbol mapper.
- The controller FSM is in the top of carrier_cfg_ctrl.

## Test plan
- Reset/defaults: after reset release, check freq=10000, cfg_ready=1, cfg_err=0. carrier_rst_n is 0 during reset and 1 one edge after release. sym_strobe pulses every 64 cycles.
- Normal change: accept 20000 at sym_cnt=10. busy is high until the strobe at sym_cnt=63. Next cycle: freq=20000, freq_upd=1 and carrier_rst_n=0 for one cycle, cfg_ready=1.
- Out-of-range: request 60000, then 0. Both are accepted by the handshake; cfg_err=1, freq unchanged, no pulses. A later valid 30000 clears cfg_err.
- Same frequency: request 10000 while freq=10000. PEND resolves at the strobe with no freq_upd and no carrier_rst_n pulse.
- Acceptance on the strobe cycle: accept 40000 when sym_cnt=63. freq changes only after the following strobe (64 cycles later). cfg_valid held during PEND with a different cfg_freq is ignored.
- Reset mid-PEND: assert rst_n low while PEND holds 45000. freq returns to 10000 and state to IDLE; 45000 is never applied after release.

Source files
------------

// File: rtl/carrier_pkg.sv
// rtl/carrier_pkg.sv - shared constants and types for the carrier configuration path
package carrier_pkg;

   localparam int FREQ_W = 16;
   localparam logic [FREQ_W-1:0] FREQ_MAX_HZ = 16'd57260;

   // Carrier-generator clock is 230,401.25 Hz; kept in millihertz to stay integral.
   localparam int unsigned CARRIER_CLK_MHZ_X1000 = 32'd230401250;

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } cfg_state_t;

   function automatic logic freq_legal(input logic [FREQ_W-1:0] f,
                                       input logic [FREQ_W-1:0] fmax);
      return (f != '0) && (f <= fmax);
   endfunction

endpackage

// File: rtl/carrier_cfg_ctrl_if.sv
// rtl/carrier_cfg_ctrl_if.sv - frequency request handshake between requester and controller
interface carrier_cfg_if;
   import carrier_pkg::*;

   logic              cfg_valid;
   logic [FREQ_W-1:0] cfg_freq;
   logic              cfg_ready;
   logic              cfg_err;

   modport master (
      output cfg_valid,
      output cfg_freq,
      input  cfg_ready,
      input  cfg_err
   );

   modport slave (
      input  cfg_valid,
      input  cfg_freq,
      output cfg_ready,
      output cfg_err
   );

endinterface

// File: rtl/carrier_cfg_ctrl_sym_timer.sv
// rtl/carrier_cfg_ctrl_sym_timer.sv - free-running symbol counter with last-cycle strobe
module sym_timer #(
   parameter int SYM_LEN = 64,
   parameter int CNT_W   = $clog2(SYM_LEN)
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [CNT_W-1:0] sym_cnt,
   output logic             sym_strobe
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(SYM_LEN - 1);

   logic [CNT_W-1:0] cnt_nxt;

   always_comb begin
      cnt_nxt = (sym_cnt == LAST) ? '0 : sym_cnt + CNT_W'(1);
   end

   // Strobe is registered from the next count so it lines up with sym_cnt == LAST.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sym_cnt    <= '0;
         sym_strobe <= 1'b0;
      end else begin
         sym_cnt    <= cnt_nxt;
         sym_strobe <= (cnt_nxt == LAST);
      end
   end

endmodule

// File: rtl/carrier_cfg_ctrl.sv
// rtl/carrier_cfg_ctrl.sv - range-checks carrier frequency requests and applies them on symbol boundaries
module carrier_cfg_ctrl
   import carrier_pkg::*;
#(
   parameter int                SYM_LEN      = 64,
   parameter logic [FREQ_W-1:0] FREQ_MAX     = FREQ_MAX_HZ,
   parameter logic [FREQ_W-1:0] DEFAULT_FREQ = 16'd10000,
   parameter int                CNT_W        = $clog2(SYM_LEN)
) (
   input  logic              clk,
   input  logic              rst_n,
   carrier_cfg_if.slave      cfg,
   output logic              busy,
   output logic [FREQ_W-1:0] freq,
   output logic              freq_upd,
   output logic              carrier_rst_n,
   output logic              sym_strobe,
   output logic [CNT_W-1:0]  sym_cnt
);

   cfg_state_t        state, state_nxt;
   logic [FREQ_W-1:0] pend_freq;
   logic              hs;
   logic              legal;
   logic              apply;
   logic              change;

   sym_timer #(
      .SYM_LEN (SYM_LEN),
      .CNT_W   (CNT_W)
   ) u_sym_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .sym_cnt    (sym_cnt),
      .sym_strobe (sym_strobe)
   );

   assign hs     = (state == IDLE) && cfg.cfg_valid;
   assign legal  = freq_legal(cfg.cfg_freq, FREQ_MAX);
   assign apply  = (state == PEND) && sym_strobe;
   assign change = apply && (pend_freq != freq);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A request accepted on a strobe cycle lands in PEND after that edge, so it waits a full symbol.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (hs && legal) state_nxt = PEND;
         PEND:    if (sym_strobe)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cfg.cfg_ready = (state == IDLE);
      busy          = (state == PEND);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_freq     <= DEFAULT_FREQ;
         freq          <= DEFAULT_FREQ;
         freq_upd      <= 1'b0;
         carrier_rst_n <= 1'b0;
         cfg.cfg_err   <= 1'b0;
      end else begin
         freq_upd      <= change;
         carrier_rst_n <= !change;
         if (change) begin
            freq <= pend_freq;
         end
         if (hs) begin
            if (legal) begin
               pend_freq   <= cfg.cfg_freq;
               cfg.cfg_err <= 1'b0;
            end else begin
               cfg.cfg_err <= 1'b1;
            end
         end
      end
   end

endmodule
